mplier_nxn: RTL and testbench
=============================

# mplier_nxn

Parametrised sequential shift-add multiplier: WIDTH×WIDTH operands, 2·WIDTH-bit product, one partial-product step per clock. Successor to the fixed 8×8 multiplier in the arithmetic datapath. Adds a start/busy/done handshake, a held result register, asynchronous reset and optional two's-complement mode. Sits between operand registers and result consumers in the datapath controller.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- mplier  in  WIDTH  multiplier, captured on accepted start.
- mcand  in  WIDTH  multiplicand, captured on accepted start.
- tc  in  1  (MPLIER_SIGNED_EN only) 1 = operands two's complement; captured with operands.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when product is updated.
- product  out  2·WIDTH  last completed result; held until the next completion.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: start=1 → load accA=0 (WIDTH+1 bits), accB=mplier, mc=mcand, count=0; go CALC. start=0 → stay.
- CALC, each cycle: if accB[0], sum = accA + mc, else sum = accA. Then {accA, accB} = {sum, accB} >> 1; count+1. After step WIDTH−1 (count = WIDTH−1) → DONE.
- Unsigned arithmetic: sum is WIDTH+1 bits, zero-extended mc; the carry bit shifts into accA and no bit is lost.
- DONE: product ← {accA[WIDTH−1:0], accB}; done=1 for this cycle; → IDLE.
- start while busy or in DONE: ignored, not queued; operand inputs are don't-care after capture.
- count is $clog2(WIDTH) bits wide and never wraps inside an operation.
- Reset (asynchronous, any state, including mid-operation): state=IDLE, busy=0, done=0, product=0, accA=accB=mc=count=0. The partial result is discarded.

## Timing
- Start accepted at edge E0. busy=1 from E0 through the edge on which DONE is entered. done=1 in the cycle after E0+WIDTH; product is valid in that same cycle.
- Total latency from the start edge to the done pulse: WIDTH+1 cycles. Minimum start-to-start spacing: WIDTH+2 cycles. A new start can be accepted on the first IDLE cycle after DONE.
- busy and done are registered outputs. done and busy are never high at the same time.
- product changes only on the edge that enters DONE, or on reset.

## Configuration
- MPLIER_SIGNED_EN defined: the tc port exists.
  - tc=1: accA, sum and mc are sign-extended and the shift is arithmetic.
  - On the final step (count = WIDTH−1), if accB[0]=1 then sum = accA − mc (Robertson correction).
  - tc=0: unsigned behaviour, bit-identical to the undefined build.
- MPLIER_SIGNED_EN undefined: the tc port is absent; unsigned only.

## Structure
- Package mplier_pkg contains:
  - state enum typedef (IDLE, CALC, DONE);
  - MPLIER_MAX_WIDTH = 32;
  - count-width function.
- Sub-module mplier_step: combinational. Inputs: accA, accB, mc, last, tc. Outputs: next accA and next accB. Contains the add/subtract and shift.
- The top level holds the FSM, counter, capture registers and product register.

## Test plan
- WIDTH=8: reset; start with mplier=13, mcand=11. Required: done pulses 9 cycles after the start edge; product=0x008F; busy high for exactly 8 cycles.
- WIDTH=8: 255×255. Required: product=0xFE01, with no carry loss. Then 0×200. Required: product=0x0000, and 0xFE01 is held until that done.
- WIDTH=8: pulse start again at cycles 3 and 8 of an operation. Required: both ignored, a single done, result unchanged. A start on the first IDLE cycle is accepted.
- WIDTH=8: assert reset_n low during cycle 4 of CALC. Required: busy, done and product go to 0 immediately; a following start for 7×6 gives 0x002A.
- MPLIER_SIGNED_EN, WIDTH=8, tc=1. Required results:
  - −3×5 → 0xFFF1;
  - −128×−128 → 0x4000;
  - 127×−1 → 0xFF81.
  - The same operands with tc=0 give the unsigned products.
- WIDTH=16 and WIDTH=3: randomised operands checked against a reference product. Required: latency is WIDTH+1 in each case.

Source files
------------

// File: rtl/mplier_pkg.sv
// rtl/mplier_pkg.sv - shared types and sizing helpers for the shift-add multiplier
package mplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MPLIER_MAX_WIDTH = 32;

    // Step counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    function automatic int count_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/mplier_step.sv
// rtl/mplier_step.sv - one combinational add/subtract-and-shift step of the multiplier
module mplier_step
    import mplier_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   acc_a,
    input  logic [WIDTH-1:0] acc_b,
    input  logic [WIDTH-1:0] mc,
    input  logic             last,
    input  logic             tc,
    output logic [WIDTH:0]   acc_a_next,
    output logic [WIDTH-1:0] acc_b_next
);

    logic [WIDTH:0] mc_x;
    logic [WIDTH:0] sum;
    logic           fill;

    always_comb begin
        mc_x = {tc & mc[WIDTH-1], mc};
        sum  = acc_a;
        // In signed mode the multiplier's sign bit carries negative weight,
        // so its partial product is subtracted on the final step.
        if (acc_b[0]) begin
            if (tc && last) begin
                sum = acc_a - mc_x;
            end else begin
                sum = acc_a + mc_x;
            end
        end
        fill       = tc & sum[WIDTH];
        acc_a_next = {fill, sum[WIDTH:1]};
        acc_b_next = {sum[0], acc_b[WIDTH-1:1]};
    end

endmodule

// File: rtl/mplier_nxn.sv
// rtl/mplier_nxn.sv - sequential WIDTHxWIDTH shift-add multiplier, signed mode under MPLIER_SIGNED_EN
module mplier_nxn
    import mplier_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   mplier,
    input  logic [WIDTH-1:0]   mcand,
`ifdef MPLIER_SIGNED_EN
    input  logic               tc,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int            CW         = count_width(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH:0]   acc_a_q;
    logic [WIDTH:0]   acc_a_next;
    logic [WIDTH-1:0] acc_b_q;
    logic [WIDTH-1:0] acc_b_next;
    logic [WIDTH-1:0] mc_q;
    logic [CW-1:0]    count_q;
    logic             tc_q;
    logic             last;

    assign last = (count_q == LAST_COUNT);

    mplier_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_a      (acc_a_q),
        .acc_b      (acc_b_q),
        .mc         (mc_q),
        .last       (last),
        .tc         (tc_q),
        .acc_a_next (acc_a_next),
        .acc_b_next (acc_b_next)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_a_q <= '0;
            acc_b_q <= '0;
            mc_q    <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_a_q <= '0;
                        acc_b_q <= mplier;
                        mc_q    <= mcand;
                        count_q <= '0;
                    end
                end
                CALC: begin
                    acc_a_q <= acc_a_next;
                    acc_b_q <= acc_b_next;
                    // Hold on the last step so a power-of-two WIDTH never wraps.
                    if (!last) begin
                        count_q <= count_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MPLIER_SIGNED_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tc_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            tc_q <= tc;
        end
    end
`else
    assign tc_q = 1'b0;
`endif

    // Status and result are registered from the next state so they line up
    // with the state they describe; product is loaded with the final step.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            busy <= (state_d == CALC);
            done <= (state_d == DONE);
            if (state_q == CALC && last) begin
                product <= {acc_a_next[WIDTH-1:0], acc_b_next};
            end
        end
    end

endmodule

// File: tb/tb_mplier_nxn.sv
// tb/tb_mplier_nxn.sv - scoreboard bench for mplier_nxn at WIDTH 8, 16 and 3
module tb_mplier_nxn;

    localparam int WID [3] = '{8, 16, 3};

    typedef struct {
        int     k;
        longint prod;
        longint due;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic [2:0]  start_v;
    logic [31:0] mpl_v [3];
    logic [31:0] mcd_v [3];
    logic [2:0]  tc_v;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [15:0] p8;
    logic [31:0] p16;
    logic [5:0]  p3;

    exp_t   exp_q [$];
    longint cyc;
    int     busy_cnt [3];
    int     n_vec;
    int     n_bad;

    mplier_nxn #(.WIDTH(8)) u8 (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start_v[0]),
        .mplier  (mpl_v[0][7:0]),
        .mcand   (mcd_v[0][7:0]),
`ifdef MPLIER_SIGNED_EN
        .tc      (tc_v[0]),
`endif
        .busy    (busy_v[0]),
        .done    (done_v[0]),
        .product (p8)
    );

    mplier_nxn #(.WIDTH(16)) u16 (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start_v[1]),
        .mplier  (mpl_v[1][15:0]),
        .mcand   (mcd_v[1][15:0]),
`ifdef MPLIER_SIGNED_EN
        .tc      (tc_v[1]),
`endif
        .busy    (busy_v[1]),
        .done    (done_v[1]),
        .product (p16)
    );

    mplier_nxn #(.WIDTH(3)) u3 (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start_v[2]),
        .mplier  (mpl_v[2][2:0]),
        .mcand   (mcd_v[2][2:0]),
`ifdef MPLIER_SIGNED_EN
        .tc      (tc_v[2]),
`endif
        .busy    (busy_v[2]),
        .done    (done_v[2]),
        .product (p3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint prod_of(input int k);
        case (k)
            0:       return longint'({48'd0, p8});
            1:       return longint'({32'd0, p16});
            default: return longint'({58'd0, p3});
        endcase
    endfunction

    function automatic bit eff_tc(input bit t);
`ifdef MPLIER_SIGNED_EN
        return t;
`else
        return 1'b0 & t;
`endif
    endfunction

    // Reference: interpret operands as integers, multiply, keep 2*w bits.
    function automatic longint ref_prod(input int w, input longint a, input longint b, input bit t);
        longint m;
        longint sa;
        longint sb;
        m  = (longint'(1) << w) - 1;
        sa = a & m;
        sb = b & m;
        if (t && ((sa >> (w - 1)) & 1) == 1) sa = sa - (longint'(1) << w);
        if (t && ((sb >> (w - 1)) & 1) == 1) sb = sb - (longint'(1) << w);
        return (sa * sb) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    task automatic issue(input int k, input longint a, input longint b, input bit t, input longint expv);
        exp_t e;
        start_v[k] = 1'b1;
        mpl_v[k]   = 32'(a);
        mcd_v[k]   = 32'(b);
        tc_v[k]    = eff_tc(t);
        @(posedge clock);
        #1;
        e.k    = k;
        e.prod = expv;
        e.due  = cyc + WID[k];
        exp_q.push_back(e);
        @(negedge clock);
        start_v[k] = 1'b0;
        mpl_v[k]   = $urandom;
        mcd_v[k]   = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL done_timeout: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clock);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            exp_q.delete();
            for (int k = 0; k < 3; k++) busy_cnt[k] = 0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (busy_v[k]) busy_cnt[k]++;
                if (done_v[k]) begin
                    check("busy_done_excl", longint'(busy_v[k]), 0);
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_done: dut %0d pulsed done, expected none", k);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_dut", k, e.k);
                        check("product", prod_of(k), e.prod);
                        check("done_cycle", cyc, e.due);
                        check("busy_cycles", busy_cnt[k], WID[k]);
                    end
                    busy_cnt[k] = 0;
                end
            end
        end
    end

    initial begin
        longint a;
        longint b;
        bit     t;
        n_vec   = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        start_v = '0;
        tc_v    = '0;
        for (int k = 0; k < 3; k++) begin
            mpl_v[k]    = '0;
            mcd_v[k]    = '0;
            busy_cnt[k] = 0;
        end
        repeat (3) @(negedge clock);
        check("rst_busy", longint'(busy_v), 0);
        check("rst_done", longint'(done_v), 0);
        check("rst_p8", prod_of(0), 0);
        check("rst_p16", prod_of(1), 0);
        check("rst_p3", prod_of(2), 0);
        @(posedge clock);
        #3 reset_n = 1'b1;
        @(negedge clock);

        issue(0, 13, 11, 0, 64'h008F);
        wait_idle();
        issue(0, 255, 255, 0, 64'hFE01);
        wait_idle();
        issue(0, 0, 200, 0, 64'h0000);
        repeat (3) @(negedge clock);
        check("hold_fe01", prod_of(0), 64'hFE01);
        wait_idle();

        // Starts during CALC and during DONE must be dropped.
        issue(0, 13, 11, 0, 64'h008F);
        repeat (3) @(negedge clock);
        start_v[0] = 1'b1;
        mpl_v[0]   = 99;
        mcd_v[0]   = 77;
        @(negedge clock);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clock);
        start_v[0] = 1'b1;
        @(negedge clock);
        start_v[0] = 1'b0;
        repeat (12) @(negedge clock);
        check("ignored_hold", prod_of(0), 64'h008F);
        check("ignored_busy", longint'(busy_v[0]), 0);
        wait_idle();

        // Asynchronous reset in the middle of CALC.
        issue(0, 200, 100, 0, ref_prod(8, 200, 100, 0));
        repeat (4) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", longint'(busy_v[0]), 0);
        check("arst_done", longint'(done_v[0]), 0);
        check("arst_product", prod_of(0), 0);
        @(negedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        issue(0, 7, 6, 0, 64'h002A);
        wait_idle();

`ifdef MPLIER_SIGNED_EN
        issue(0, -3, 5, 1, 64'hFFF1);
        wait_idle();
        issue(0, -128, -128, 1, 64'h4000);
        wait_idle();
        issue(0, 127, -1, 1, 64'hFF81);
        wait_idle();
        issue(0, -3, 5, 0, 64'h04F1);
        wait_idle();
        issue(0, -128, -128, 0, 64'h4000);
        wait_idle();
        issue(0, 127, -1, 0, 64'h7E81);
        wait_idle();
`endif

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 20; i++) begin
                a = longint'($urandom);
                b = longint'($urandom);
                t = 1'($urandom_range(0, 1));
                if (i == 0) begin
                    a = -1;
                    b = -1;
                end
                issue(k, a, b, t, ref_prod(WID[k], a, b, eff_tc(t)));
                wait_idle();
            end
        end

        repeat (5) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
